// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: width, opcodes, flag bit
// positions and the stored FIFO entry layout.
package alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic [3:0]       flags;
    logic             err;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between the ALU units, the result stage and
// the downstream consumer. The stage uses the slave view; the upstream /
// downstream side uses the master view.
interface alu_result_if import alu_pkg::*; #(
  parameter int WIDTH = ALU_W
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] and_s;
  logic [WIDTH-1:0] or_s;
  logic [WIDTH-1:0] xor_s;
  logic [WIDTH-1:0] not_s;
  logic [WIDTH-1:0] sum_s;
  logic             sum_cout;
  logic             a_msb;
  logic             b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic             out_err;

  modport slave (
    input  in_valid, op, and_s, or_s, xor_s, not_s, sum_s, sum_cout,
           a_msb, b_msb, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_err
  );

  modport master (
    output in_valid, op, and_s, or_s, xor_s, not_s, sum_s, sum_cout,
           a_msb, b_msb, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_err
  );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V flag and reserved-opcode derivation for the
// selected ALU result.
module alu_flag_gen import alu_pkg::*; #(
  parameter int WIDTH = ALU_W
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] result,
  input  logic             sum_cout,
  input  logic             a_msb,
  input  logic             b_msb,
  output logic [3:0]       flags,
  output logic             err
);

  logic res_msb;
  assign res_msb = result[WIDTH-1];

  // Flags from the result; C/V only meaningful for the adder path.
  always_comb begin
    flags         = '0;
    err           = 1'b0;
    flags[FLAG_N] = res_msb;
    flags[FLAG_Z] = (result == '0);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOT: ;
      OP_ADD: begin
        flags[FLAG_C] = sum_cout;
        flags[FLAG_V] = (a_msb == b_msb) && (res_msb != a_msb);
      end
      OP_SUB: begin
        // b_msb is the un-inverted operand, so overflow needs differing signs.
        flags[FLAG_C] = sum_cout;
        flags[FLAG_V] = (a_msb != b_msb) && (res_msb != a_msb);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage of the ALU: selects the unit output by opcode,
// attaches flags, and buffers results in a 2-entry valid/ready FIFO.
module alu_result_stage import alu_pkg::*; (
  input  logic         clk,
  input  logic         rst_n,
  alu_result_if.slave  bus
);

  localparam int WIDTH = ALU_W;

  logic [WIDTH-1:0] sel_result;
  logic [3:0]       new_flags;
  logic             new_err;

  alu_entry_t       mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  // Pick the unit output named by the opcode; reserved opcodes give zero.
  always_comb begin
    sel_result = '0;
    case (bus.op)
      OP_AND:  sel_result = bus.and_s;
      OP_OR:   sel_result = bus.or_s;
      OP_XOR:  sel_result = bus.xor_s;
      OP_NOT:  sel_result = bus.not_s;
      OP_ADD:  sel_result = bus.sum_s;
      OP_SUB:  sel_result = bus.sum_s;
      default: sel_result = '0;
    endcase
  end

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .op       (bus.op),
    .result   (sel_result),
    .sum_cout (bus.sum_cout),
    .a_msb    (bus.a_msb),
    .b_msb    (bus.b_msb),
    .flags    (new_flags),
    .err      (new_err)
  );

  // Handshake decode; every output comes from registered state only.
  assign bus.in_ready   = (count != 2'd2);
  assign bus.out_valid  = (count != 2'd0);
  assign push           = bus.in_valid && bus.in_ready;
  assign pop            = bus.out_valid && bus.out_ready;
  assign bus.out_result = mem[rd_ptr].result;
  assign bus.out_flags  = mem[rd_ptr].flags;
  assign bus.out_err    = mem[rd_ptr].err;

  // FIFO storage, pointers and occupancy; storage clears on reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{result: sel_result, flags: new_flags, err: new_err};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: reference queue model plus directed cases.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  logic [2:0]  cur_op = '0;
  logic [15:0] cur_a  = '0;
  logic [15:0] cur_b  = '0;

  alu_entry_t  q[$];
  logic [15:0] got[$];

  alu_result_if #(.WIDTH(ALU_W)) bus ();

  alu_result_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Expected entry straight from the arithmetic meaning of each opcode.
  function automatic alu_entry_t model(input logic [2:0] o, input logic [15:0] a,
                                       input logic [15:0] b);
    alu_entry_t  e;
    logic [15:0] r;
    logic        c, v, er;
    int          sa, sb, sr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = '0; c = 1'b0; v = 1'b0; er = 1'b0;
    case (o)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~a;
      3'd4: begin
        r  = a + b;
        c  = (int'(a) + int'(b)) > 65535;
        sr = sa + sb;
        v  = (sr > 32767) || (sr < -32768);
      end
      3'd5: begin
        r  = a - b;
        c  = (a >= b);
        sr = sa - sb;
        v  = (sr > 32767) || (sr < -32768);
      end
      default: er = 1'b1;
    endcase
    e.result = r;
    e.flags  = {r[15], (r == 16'h0), c, v};
    e.err    = er;
    return e;
  endfunction

  // Present a result set as the upstream units would produce it from a, b.
  task automatic drive(input logic v, input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b);
    logic [16:0] s;
    cur_op = o; cur_a = a; cur_b = b;
    if (o == 3'd5) s = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else           s = {1'b0, a} + {1'b0, b};
    bus.in_valid = v;
    bus.op       = o;
    bus.and_s    = a & b;
    bus.or_s     = a | b;
    bus.xor_s    = a ^ b;
    bus.not_s    = ~a;
    bus.sum_s    = s[15:0];
    bus.sum_cout = s[16];
    bus.a_msb    = a[15];
    bus.b_msb    = b[15];
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Reference FIFO: pop the head when taken, append when space existed.
  always @(posedge clk or negedge rst_n) begin
    bit do_pop, do_push;
    if (!rst_n) q.delete();
    else begin
      do_push = bus.in_valid && (q.size() < 2);
      do_pop  = (q.size() > 0) && bus.out_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(model(cur_op, cur_a, cur_b));
    end
  end

  // Compare DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("out_result", 32'(bus.out_result), 32'(q[0].result));
        chk("out_flags", 32'(bus.out_flags), 32'(q[0].flags));
        chk("out_err", 32'(bus.out_err), 32'(q[0].err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    alu_entry_t exp_e;
    logic       ir;
    logic [15:0] val;
    bus.out_ready = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 16'h0);

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_result", 32'(bus.out_result), 32'd0);
    chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // AND, one-cycle latency
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd0, 16'h0475, 16'h5976);
    @(posedge clk); #1; drive(1'b0, 3'd0, 16'h0, 16'h0);
    @(negedge clk);
    chk("and_valid", 32'(bus.out_valid), 32'd1);
    chk("and_result", 32'(bus.out_result), 32'h0074);
    chk("and_flags", 32'(bus.out_flags), 32'b0000);
    chk("and_err", 32'(bus.out_err), 32'd0);

    // ADD overflow
    @(posedge clk); #1; drive(1'b1, 3'd4, 16'h4000, 16'h4000);
    @(posedge clk); #1; drive(1'b0, 3'd0, 16'h0, 16'h0);
    @(negedge clk);
    chk("add_ovf_result", 32'(bus.out_result), 32'h8000);
    chk("add_ovf_flags", 32'(bus.out_flags), 32'b1001);

    // SUB equal operands
    @(posedge clk); #1; drive(1'b1, 3'd5, 16'h1234, 16'h1234);
    @(posedge clk); #1; drive(1'b0, 3'd0, 16'h0, 16'h0);
    @(negedge clk);
    chk("sub_eq_result", 32'(bus.out_result), 32'h0000);
    chk("sub_eq_flags", 32'(bus.out_flags), 32'b0110);

    // Backpressure: three offers with the consumer stalled
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    val = 16'd1;
    drive(1'b1, 3'd0, val, val);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      ir = bus.in_ready;
      chk("bp_in_ready", 32'(ir), (cyc < 2) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      if (ir && val < 16'd3) begin
        val = val + 16'd1;
        drive(1'b1, 3'd0, val, val);
      end
    end
    bus.out_ready = 1'b1;
    got.delete();
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) got.push_back(bus.out_result);
      ir = bus.in_ready;
      @(posedge clk); #1;
      if (bus.in_valid && ir) bus.in_valid = 1'b0;
    end
    chk("bp_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("bp_order", (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(i + 1));

    // Push and pop together at occupancy 1
    drive(1'b1, 3'd4, 16'h0101, 16'h0202);
    exp_e = model(3'd4, 16'h0101, 16'h0202);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  o;
      logic [15:0] a, b;
      o = 3'($urandom_range(0, 5));
      a = pick_operand();
      b = pick_operand();
      drive(1'b1, o, a, b);
      @(negedge clk);
      chk("pp_in_ready", 32'(bus.in_ready), 32'd1);
      chk("pp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("pp_result", 32'(bus.out_result), 32'(exp_e.result));
      exp_e = model(o, a, b);
      @(posedge clk); #1;
    end
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
      @(posedge clk); #1;
    end
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reserved opcode, then reset with two entries held
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd7, 16'hABCD, 16'h1234);
    @(posedge clk); #1;
    drive(1'b1, 3'd0, 16'hFFFF, 16'h00FF);
    @(negedge clk);
    chk("rsv_result", 32'(bus.out_result), 32'h0000);
    chk("rsv_flags", 32'(bus.out_flags), 32'b0100);
    chk("rsv_err", 32'(bus.out_err), 32'd1);
    @(posedge clk); #1;
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_result", 32'(bus.out_result), 32'd0);
    chk("arst_out_flags", 32'(bus.out_flags), 32'd0);
    chk("arst_out_err", 32'(bus.out_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage of the 16-bit ALU, directly downstream of the bitwise units (AND, OR, XOR, NOT) and the adder/subtractor. Selects the unit output named by the opcode, derives N/Z/C/V flags, and holds results in a 2-entry FIFO behind a valid/ready handshake. Every ALU result therefore leaves the datapath registered, flagged and flow-controlled.

## Interface
- WIDTH, 16, operand/result width; all arithmetic rules below scale with it.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream presents a result set
- in_ready  out  1  stage can accept; equals !full
- op  in  3  opcode: 0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 SUB, 6–7 reserved
- and_s / or_s / xor_s / not_s  in  WIDTH  bitwise unit outputs
- sum_s  in  WIDTH  adder output (SUB is computed upstream as a + ~b + 1)
- sum_cout  in  1  adder carry-out
- a_msb, b_msb  in  1  operand sign bits as applied to the adder (b_msb is the un-inverted b)
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_result  out  WIDTH  head result
- out_flags  out  4  {N, Z, C, V}
- out_err  out  1  head entry carried a reserved opcode

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- Result select: op 0–5 → corresponding unit output; op 6–7 → result 0, out_err 1.
- N = result[WIDTH-1]; Z = (result == 0), including for reserved ops.
- C: ADD/SUB → sum_cout (SUB: 1 = no borrow); other ops → 0.
- V: ADD → (a_msb == b_msb) && (result msb != a_msb); SUB → (a_msb != b_msb) && (result msb != a_msb); other ops → 0.
- Flags and err are computed at push and stored with the result. Outputs never depend combinationally on the in_* data.
- FIFO: 2 entries, 1-bit rd/wr pointers that wrap 1→0, 2-bit count 0..2.
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at count 1. At count 0 there is no pop. At count 2 there is no push.
- Output fields show the entry at rd pointer. When out_valid = 0 the output fields are don't-care but are held stable.

## Timing
- Reset (async assert, synchronous-style deassert by the top level): count = 0, pointers = 0, all storage 0.
  - out_valid = 0, out_result = 0, out_flags = 0, out_err = 0.
  - in_ready = 1 once rst_n is high.
- Latency: a push at edge k appears on the outputs with out_valid = 1 immediately after edge k. Minimum latency is 1 cycle.
- Throughput: one result per cycle while out_ready is held high.
- in_ready drops in the cycle after the second unpopped push. It rises the cycle after a pop from full.
- out_valid, out_result, out_flags and out_err are stable while out_valid && !out_ready.
- Reset asserted mid-stream discards all entries immediately. in_valid sampled during reset is ignored.

## Structure
- Shared package alu_pkg holds:
  - ALU_W = 16
  - opcode localparams OP_AND … OP_SUB
  - flag bit indices FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0
  - the packed entry typedef {result, flags, err}
- One natural sub-module: alu_flag_gen. It is combinational: op, selected result, sum_cout, a_msb and b_msb in; flags and err out. The FIFO and handshake logic stay in alu_result_stage.

## Test plan
- AND: op 0, and_s = 16'h0074 (from a = 16'h0475, b = 16'h5976), out_ready = 1 → one cycle later out_result 16'h0074, flags 4'b0000, err 0.
- ADD overflow: op 4, sum_s = 16'h8000, cout 0, a_msb 0, b_msb 0 → result 16'h8000, flags {N1, Z0, C0, V1}.
- SUB equal: op 5, sum_s = 16'h0000, cout 1, a_msb = b_msb = 0 → flags {N0, Z1, C1, V0}.
- Backpressure: out_ready = 0, offer three pushes with values 1, 2, 3.
  - in_ready goes low after the second push; the third is held off.
  - Raising out_ready then delivers 1, 2, 3 in order with no loss or duplication.
- Simultaneous push/pop at count 1 for 8 consecutive cycles → count stays 1, outputs track inputs with 1-cycle latency.
- Reserved op 7 → result 0, flags {0, 1, 0, 0}, err 1. Then assert rst_n = 0 with 2 entries held → out_valid 0 and all outputs 0 immediately (asynchronously); in_ready 1 after release.
